alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Sequencer/arbiter that time-shares one 64-bit ALU core (built on the add_64bit ripple adder)
//  between two requesters: req0 = execute stage (OPq, may set CC), req1 = address/aux path.
//  Owns the operand/result registers, a multi-cycle execute counter and the Y86 condition-code
//  register (ZF/SF/OF). Sits in the execute stage in front of the ALU.
// PARAMETERS
//  WIDTH  64  operand/result width (add_64bit is 64-bit; only 64 is supported)
//  LAT    1   cycles the latched operands are held on the ALU core before result capture (1..4)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 has an operation
//  req0_ready  out  1      handshake grant to requester 0 (combinational)
//  req0_fn     in   2      00 add, 01 sub (a-b), 10 and, 11 xor
//  req0_a      in   WIDTH  operand a
//  req0_b      in   WIDTH  operand b
//  req0_setcc  in   1      update CC register when this op completes
//  req1_valid  in   1      requester 1 has an operation
//  req1_ready  out  1      handshake grant to requester 1 (combinational)
//  req1_fn     in   2      as req0_fn
//  req1_a      in   WIDTH  operand a
//  req1_b      in   WIDTH  operand b
//  resp0_valid out  1      1-cycle pulse: result belongs to requester 0
//  resp1_valid out  1      1-cycle pulse: result belongs to requester 1
//  result      out  WIDTH  registered ALU result, held until next capture
//  overflow    out  1      registered signed overflow of result
//  cc_zf       out  1      condition code: zero
//  cc_sf       out  1      condition code: sign
//  cc_of       out  1      condition code: overflow
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE, counter 0, last_grant=1, result=0, overflow=0,
//    resp*_valid=0, cc_zf=1, cc_sf=0, cc_of=0. req*_ready forced 0 while rst=1.
//  - FSM: IDLE -> EXEC (on handshake) -> DONE (after LAT EXEC cycles) -> IDLE. Never stalls.
//  - IDLE: reqN_ready = grantN. Only one ready high per cycle. Grant rule: single valid -> that
//    one; both valid -> the one != last_grant (round robin). Handshake = valid & ready; at that
//    edge latch fn/a/b/setcc/owner, update last_grant, counter<=LAT-1, go EXEC.
//  - Requester must hold valid/fn/a/b stable until ready; dropping valid before grant is allowed.
//  - EXEC: ready outputs 0. ALU core driven from latched operands only. Counter decrements each
//    cycle; on counter==0 edge capture result/overflow, go DONE.
//  - DONE: resp{owner}_valid=1 for exactly this cycle; ready outputs 0; next edge -> IDLE.
//    Handshake edge to resp_valid high = LAT+1 cycles; max throughput 1 op per LAT+2 cycles.
//  - ALU: add = a+b (cin=0); sub = a+~b with cin=1; and/xor bitwise. All mod 2^64.
//    overflow (add/sub only) = signed overflow of the adder; 0 for and/xor.
//  - CC: updated at the same edge resp0_valid rises, only if owner=0 and setcc=1:
//    ZF=(result==0), SF=result[63], OF=overflow. req1 ops never touch CC.
//  - rst asserted mid-EXEC/DONE: op abandoned, no resp pulse, all regs to reset values.
//  - Inputs of the non-granted requester are ignored; no request queueing beyond the valid line.
// TESTING
//  1 req0 add a=0x9DE b=0x1B2B setcc=1, LAT=1 -> resp0_valid 2 cycles after handshake,
//    result=0x2509, overflow=0, ZF=0 SF=0 OF=0.
//  2 req0 add a=0x7FFF_FFFF_FFFF_FFFF b=1 setcc=1 -> result=0x8000_0000_0000_0000, OF=1, SF=1, ZF=0.
//  3 req1 sub a=5 b=5 -> result=0, resp1_valid pulse, CC unchanged from prior value (ZF stays 0).
//  4 req0 and req1 valid every cycle from reset -> grants alternate 0,1,0,1; exactly one ready
//    per IDLE cycle; resp owner matches grant order.
//  5 req0 add a=-25 (0x..FFE7) b=-44 (0x..FFD4), LAT=3 -> result=0xFFFF_FFFF_FFFF_FFBB,
//    overflow=0, resp 4 cycles after handshake, SF=1.
//  6 rst pulsed during EXEC -> no resp pulse, result=0, ZF=1 SF=0 OF=0, next request served normally.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Time-shares one ripple-carry ALU core between the execute stage (req0) and the aux path (req1).
// Owns the latched operands, the execute counter, the result register and the Y86 ZF/SF/OF register.

module add_64bit #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf = carry[W] ^ carry[W - 1];
endmodule

module alu_share_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fn,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_setcc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fn,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);
    localparam int unsigned CW     = 2;
    localparam logic [1:0]  FN_ADD = 2'b00;
    localparam logic [1:0]  FN_SUB = 2'b01;
    localparam logic [1:0]  FN_AND = 2'b10;
    localparam logic [1:0]  FN_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic            last_grant;
    logic            owner;
    logic            op_setcc;
    logic [1:0]      op_fn;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic            grant0;
    logic            grant1;
    logic            take;
    logic            fire;

    logic            is_sub;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic            add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic            alu_ovf;

    // Next state and grant; round robin only matters when both requesters are valid.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        take       = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || last_grant)) begin
                    grant0 = 1'b1;
                end else if (req1_valid) begin
                    grant1 = 1'b1;
                end
                take = (grant0 || grant1) && !rst;
                if (take) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (count == '0) begin
                    fire       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req0_ready = grant0 & ~rst;
    assign req1_ready = grant1 & ~rst;

    // Shared ALU core, fed only from the latched operands.
    assign is_sub = (op_fn == FN_SUB);
    assign add_b  = is_sub ? ~op_b : op_b;

    add_64bit #(.W(WIDTH)) u_add (
        .a   (op_a),
        .b   (add_b),
        .cin (is_sub),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        alu_res = add_sum;
        alu_ovf = add_ovf;
        case (op_fn)
            FN_ADD, FN_SUB: begin
                alu_res = add_sum;
                alu_ovf = add_ovf;
            end
            FN_AND: begin
                alu_res = op_a & op_b;
                alu_ovf = 1'b0;
            end
            FN_XOR: begin
                alu_res = op_a ^ op_b;
                alu_ovf = 1'b0;
            end
            default: begin
                alu_res = add_sum;
                alu_ovf = add_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            op_setcc    <= 1'b0;
            op_fn       <= FN_ADD;
            op_a        <= '0;
            op_b        <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            cc_zf       <= 1'b1;
            cc_sf       <= 1'b0;
            cc_of       <= 1'b0;
        end else begin
            state       <= state_next;
            resp0_valid <= fire & ~owner;
            resp1_valid <= fire & owner;

            if (take) begin
                owner      <= grant1;
                last_grant <= grant1;
                op_fn      <= grant1 ? req1_fn : req0_fn;
                op_a       <= grant1 ? req1_a : req0_a;
                op_b       <= grant1 ? req1_b : req0_b;
                op_setcc   <= grant0 & req0_setcc;
                count      <= CW'(LAT - 1);
            end else if ((state == EXEC) && (count != '0)) begin
                count <= count - CW'(1);
            end

            // Result and condition codes land on the edge that raises the response pulse.
            if (fire) begin
                result   <= alu_res;
                overflow <= alu_ovf;
                if (!owner && op_setcc) begin
                    cc_zf <= (alu_res == '0);
                    cc_sf <= alu_res[WIDTH-1];
                    cc_of <= alu_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (LAT=1 and LAT=3) checked every cycle
// against a cycle-count transaction model, plus hand-computed literal expectations.

module tb_alu_share_arbiter;
    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] AND = 2'b10;
    localparam logic [1:0] XOR = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0 [2];
    logic        v1 [2];
    logic [1:0]  f0 [2];
    logic [1:0]  f1 [2];
    logic [63:0] a0 [2];
    logic [63:0] b0 [2];
    logic [63:0] a1 [2];
    logic [63:0] b1 [2];
    logic        sc [2];
    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic [63:0] res [2];
    logic        ov [2];
    logic        zf [2];
    logic        sf [2];
    logic        of [2];

    int n_cmp = 0;
    int n_err = 0;

    alu_share_arbiter #(.WIDTH(64), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_fn(f0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
        .req0_setcc(sc[0]),
        .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_fn(f1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
        .resp0_valid(rv0[0]), .resp1_valid(rv1[0]), .result(res[0]), .overflow(ov[0]),
        .cc_zf(zf[0]), .cc_sf(sf[0]), .cc_of(of[0])
    );

    alu_share_arbiter #(.WIDTH(64), .LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_fn(f0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
        .req0_setcc(sc[1]),
        .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_fn(f1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
        .resp0_valid(rv0[1]), .resp1_valid(rv1[1]), .result(res[1]), .overflow(ov[1]),
        .cc_zf(zf[1]), .cc_sf(sf[1]), .cc_of(of[1])
    );

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (inst %0d, t=%0t): got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference ALU from arithmetic definitions: {overflow, result}.
    function automatic logic [64:0] ref_alu(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        o;
        o = 1'b0;
        case (fn)
            ADD: begin r = a + b; o = (a[63] == b[63]) && (r[63] != a[63]); end
            SUB: begin r = a - b; o = (a[63] != b[63]) && (r[63] != a[63]); end
            AND: r = a & b;
            default: r = a ^ b;
        endcase
        return {o, r};
    endfunction

    // Transaction model: free flag, pending op with its response cycle, expected outputs.
    bit          m_free [2];
    bit          m_last [2];
    bit          m_pend [2];
    int          m_resp_cyc [2];
    bit          m_owner [2];
    bit          m_psc [2];
    logic [64:0] m_pres [2];
    bit          e_r0 [2];
    bit          e_r1 [2];
    logic [63:0] e_res [2];
    bit          e_ov [2];
    bit          e_zf [2];
    bit          e_sf [2];
    bit          e_of [2];
    int          cyc = 0;

    task automatic model_reset(input int d);
        m_free[d] = 1'b1; m_last[d] = 1'b1; m_pend[d] = 1'b0;
        e_r0[d] = 1'b0; e_r1[d] = 1'b0; e_res[d] = '0; e_ov[d] = 1'b0;
        e_zf[d] = 1'b1; e_sf[d] = 1'b0; e_of[d] = 1'b0;
    endtask

    initial begin
        bit g0;
        bit g1;
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                g0 = 1'b0;
                g1 = 1'b0;
                if (!rst && m_free[d]) begin
                    if (v0[d] && v1[d]) begin
                        if (m_last[d]) g0 = 1'b1; else g1 = 1'b1;
                    end else if (v0[d]) begin
                        g0 = 1'b1;
                    end else if (v1[d]) begin
                        g1 = 1'b1;
                    end
                end
                chk("req0_ready", d, 64'(rdy0[d]), 64'(g0));
                chk("req1_ready", d, 64'(rdy1[d]), 64'(g1));
                chk("resp0_valid", d, 64'(rv0[d]), 64'(e_r0[d]));
                chk("resp1_valid", d, 64'(rv1[d]), 64'(e_r1[d]));
                chk("result", d, res[d], e_res[d]);
                chk("overflow", d, 64'(ov[d]), 64'(e_ov[d]));
                chk("cc", d, 64'({zf[d], sf[d], of[d]}), 64'({e_zf[d], e_sf[d], e_of[d]}));

                if (rst) begin
                    model_reset(d);
                end else begin
                    e_r0[d] = 1'b0;
                    e_r1[d] = 1'b0;
                    if (g0 || g1) begin
                        m_pend[d]     = 1'b1;
                        m_free[d]     = 1'b0;
                        m_last[d]     = g1;
                        m_owner[d]    = g1;
                        m_resp_cyc[d] = cyc + lat_of(d) + 1;
                        m_pres[d]     = g1 ? ref_alu(f1[d], a1[d], b1[d]) : ref_alu(f0[d], a0[d], b0[d]);
                        m_psc[d]      = g0 && sc[d];
                    end
                    if (m_pend[d] && (cyc + 1 == m_resp_cyc[d])) begin
                        e_r0[d]  = !m_owner[d];
                        e_r1[d]  = m_owner[d];
                        e_res[d] = m_pres[d][63:0];
                        e_ov[d]  = m_pres[d][64];
                        if (m_psc[d]) begin
                            e_zf[d] = (m_pres[d][63:0] == 64'd0);
                            e_sf[d] = m_pres[d][63];
                            e_of[d] = m_pres[d][64];
                        end
                    end else if (m_pend[d] && (cyc + 1 == m_resp_cyc[d] + 1)) begin
                        m_pend[d] = 1'b0;
                        m_free[d] = 1'b1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input bit req, input logic [1:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input bit setcc);
        int n;
        if (!req) begin
            v0[d] = 1'b1; f0[d] = fn; a0[d] = a; b0[d] = b; sc[d] = setcc;
        end else begin
            v1[d] = 1'b1; f1[d] = fn; a1[d] = a; b1[d] = b;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if ((req ? rdy1[d] : rdy0[d]) === 1'b1) break;
            n++;
            if (n > 20) begin
                n_cmp++;
                n_err++;
                $display("FAIL grant_timeout (inst %0d req%0d): no ready within 20 cycles", d, req);
                break;
            end
        end
        step();
        if (!req) v0[d] = 1'b0; else v1[d] = 1'b0;
    endtask

    // Leaves the bench at the negedge of the response cycle.
    task automatic wait_resp(input int d, input bit req, input int lat_exp);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 12) begin
            @(negedge clk);
            n++;
            hit = ((req ? rv1[d] : rv0[d]) === 1'b1);
        end
        chk("resp_latency", d, 64'(n), 64'(lat_exp));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            v0[d] = 1'b0; v1[d] = 1'b0; f0[d] = ADD; f1[d] = ADD; sc[d] = 1'b0;
            a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(0, 0, ADD, 64'h9DE, 64'h1B2B, 1'b1);
        wait_resp(0, 0, 2);
        chk("t1_result", 0, res[0], 64'h2509);
        chk("t1_ovf", 0, 64'(ov[0]), 64'd0);
        chk("t1_cc", 0, 64'({zf[0], sf[0], of[0]}), 64'b000);
        step();

        issue(0, 0, ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        wait_resp(0, 0, 2);
        chk("t2_result", 0, res[0], 64'h8000_0000_0000_0000);
        chk("t2_cc", 0, 64'({zf[0], sf[0], of[0]}), 64'b011);
        step();

        issue(0, 1, SUB, 64'd5, 64'd5, 1'b0);
        wait_resp(0, 1, 2);
        chk("t3_result", 0, res[0], 64'd0);
        chk("t3_cc_held", 0, 64'({zf[0], sf[0], of[0]}), 64'b011);
        step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        v0[0] = 1'b1; f0[0] = ADD; a0[0] = 64'd1;  b0[0] = 64'd2;  sc[0] = 1'b1;
        v1[0] = 1'b1; f1[0] = XOR; a1[0] = 64'hF0; b1[0] = 64'hFF;
        @(negedge clk);
        chk("t4_first_grant", 0, 64'({rdy0[0], rdy1[0]}), 64'b10);
        repeat (3) @(negedge clk);
        chk("t4_second_grant", 0, 64'({rdy0[0], rdy1[0]}), 64'b01);
        repeat (2) @(negedge clk);
        chk("t4_second_result", 0, res[0], 64'h0F);
        chk("t4_second_owner", 0, 64'({rv0[0], rv1[0]}), 64'b01);
        repeat (1) @(negedge clk);
        chk("t4_third_grant", 0, 64'({rdy0[0], rdy1[0]}), 64'b10);
        repeat (6) @(negedge clk);
        step();
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        repeat (6) step();

        issue(0, 0, ADD, 64'd100, 64'd200, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_result", 0, res[0], 64'd0);
        chk("t6_cc", 0, 64'({zf[0], sf[0], of[0]}), 64'b100);
        step();
        issue(0, 0, ADD, 64'h9DE, 64'h1B2B, 1'b1);
        wait_resp(0, 0, 2);
        chk("t6_after_result", 0, res[0], 64'h2509);
        step();

        issue(0, 0, XOR, 64'h1234, 64'h1234, 1'b1);
        wait_resp(0, 0, 2);
        chk("xor_zero_cc", 0, 64'({zf[0], sf[0], of[0]}), 64'b100);
        step();
        issue(0, 0, AND, 64'hF0F0, 64'h0FF0, 1'b1);
        wait_resp(0, 0, 2);
        chk("and_result", 0, res[0], 64'h00F0);
        step();

        issue(1, 0, ADD, 64'hFFFF_FFFF_FFFF_FFE7, 64'hFFFF_FFFF_FFFF_FFD4, 1'b1);
        wait_resp(1, 0, 4);
        chk("t5_result", 1, res[1], 64'hFFFF_FFFF_FFFF_FFBB);
        chk("t5_ovf", 1, 64'(ov[1]), 64'd0);
        chk("t5_cc", 1, 64'({zf[1], sf[1], of[1]}), 64'b010);
        step();
        issue(1, 1, SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        wait_resp(1, 1, 4);
        chk("sub_ovf_result", 1, res[1], 64'h7FFF_FFFF_FFFF_FFFF);
        chk("sub_ovf_flag", 1, 64'(ov[1]), 64'd1);
        chk("sub_cc_held", 1, 64'({zf[1], sf[1], of[1]}), 64'b010);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
